// File: rtl/axi_ram_slave_if.sv
// AXI3 single-beat bus bundle between the transfer bridge (master) and the RAM endpoint (slave).
interface axi_ram_slave_if;
    logic [3:0]  arid;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic [1:0]  arlock;
    logic [3:0]  arcache;
    logic [2:0]  arprot;
    logic        arvalid;
    logic        arready;
    logic [3:0]  rid;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [3:0]  awid;
    logic [31:0] awaddr;
    logic [7:0]  awlen;
    logic [2:0]  awsize;
    logic [1:0]  awburst;
    logic [1:0]  awlock;
    logic [3:0]  awcache;
    logic [2:0]  awprot;
    logic        awvalid;
    logic        awready;
    logic [3:0]  wid;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wlast;
    logic        wvalid;
    logic        wready;
    logic [3:0]  bid;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wid, wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wid, wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );
endinterface

// File: rtl/axi_ram_slave.sv
// Single-beat AXI3 RAM endpoint: 2-deep in-order read queue with fixed latency,
// independent AW/W holding slots committing into a byte-writable word RAM.
module axi_ram_slave #(
    parameter int unsigned MEM_AW       = 12,
    parameter int unsigned READ_LATENCY = 2
) (
    input  logic             clk,
    input  logic             resetn,
    axi_ram_slave_if.slave   bus
);
    localparam int unsigned DEPTH = 2 ** MEM_AW;
    localparam int unsigned IW    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned LW    = 3;

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} rd_state_t;

    logic [DW-1:0]     mem [DEPTH];

    logic              ready_q;
    logic [1:0]        count_q;
    logic [IW-1:0]     q_id  [2];
    logic [MEM_AW-1:0] q_idx [2];
    rd_state_t         state_q, state_d;
    logic [LW-1:0]     lat_q;
    logic [DW-1:0]     rdata_q;
    logic [IW-1:0]     rid_q;

    logic              aw_full_q, w_full_q, bvalid_q;
    logic [IW-1:0]     aw_id_q, bid_q;
    logic [MEM_AW-1:0] aw_idx_q;
    logic [DW-1:0]     w_data_q;
    logic [3:0]        w_strb_q;

    logic ar_rdy_c, aw_rdy_c, w_rdy_c;
    logic ar_push_c, r_pop_c, aw_hs_c, w_hs_c, commit_c;
    logic lat_done_c, lat_load_c, lat_inc_c, r_load_c, rvalid_c, wr_slot_c;
    logic [1:0] remaining_c;
    logic unused_bits;

    // Ready goes high on the first edge after reset release
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) ready_q <= 1'b0;
        else         ready_q <= 1'b1;
    end

    assign ar_rdy_c    = ready_q && (count_q != 2'd2);
    assign aw_rdy_c    = ready_q && !aw_full_q;
    assign w_rdy_c     = ready_q && !w_full_q;
    assign ar_push_c   = bus.arvalid && ar_rdy_c;
    assign r_pop_c     = rvalid_c && bus.rready;
    assign aw_hs_c     = bus.awvalid && aw_rdy_c;
    assign w_hs_c      = bus.wvalid && w_rdy_c;
    assign commit_c    = aw_full_q && w_full_q && (!bvalid_q || bus.bready);
    assign lat_done_c  = (lat_q == LW'(READ_LATENCY));
    assign remaining_c = count_q - 2'd1 + 2'(ar_push_c);
    assign wr_slot_c   = !r_pop_c && count_q[0];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state_q <= S_IDLE;
        else         state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (ar_push_c) state_d = S_WAIT;
            S_WAIT:  if (lat_done_c) state_d = S_RESP;
            S_RESP:  if (r_pop_c) state_d = (remaining_c != 2'd0) ? S_WAIT : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        rvalid_c   = 1'b0;
        lat_load_c = 1'b0;
        lat_inc_c  = 1'b0;
        r_load_c   = 1'b0;
        rvalid_c   = (state_q == S_RESP);
        lat_load_c = (state_d == S_WAIT) && (state_q != S_WAIT);
        lat_inc_c  = (state_q == S_WAIT) && !lat_done_c;
        r_load_c   = (state_q == S_WAIT) && lat_done_c;
    end

    // Read queue (head always in slot 0), latency counter and R payload
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            count_q  <= 2'd0;
            q_id[0]  <= '0;
            q_id[1]  <= '0;
            q_idx[0] <= '0;
            q_idx[1] <= '0;
            lat_q    <= '0;
            rdata_q  <= '0;
            rid_q    <= '0;
        end else begin
            count_q <= count_q + 2'(ar_push_c) - 2'(r_pop_c);
            if (r_pop_c) begin
                q_id[0]  <= q_id[1];
                q_idx[0] <= q_idx[1];
            end
            if (ar_push_c) begin
                q_id[wr_slot_c]  <= bus.arid;
                q_idx[wr_slot_c] <= bus.araddr[MEM_AW+1:2];
            end
            if (lat_load_c)     lat_q <= LW'(1);
            else if (lat_inc_c) lat_q <= lat_q + LW'(1);
            if (r_load_c) begin
                rdata_q <= mem[q_idx[0]];
                rid_q   <= q_id[0];
            end
        end
    end

    // Write holding slots and B response
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            aw_full_q <= 1'b0;
            aw_id_q   <= '0;
            aw_idx_q  <= '0;
            w_full_q  <= 1'b0;
            w_data_q  <= '0;
            w_strb_q  <= '0;
            bvalid_q  <= 1'b0;
            bid_q     <= '0;
        end else begin
            if (commit_c) aw_full_q <= 1'b0;
            else if (aw_hs_c) begin
                aw_full_q <= 1'b1;
                aw_id_q   <= bus.awid;
                aw_idx_q  <= bus.awaddr[MEM_AW+1:2];
            end
            if (commit_c) w_full_q <= 1'b0;
            else if (w_hs_c) begin
                w_full_q <= 1'b1;
                w_data_q <= bus.wdata;
                w_strb_q <= bus.wstrb;
            end
            if (commit_c) begin
                bvalid_q <= 1'b1;
                bid_q    <= aw_id_q;
            end else if (bus.bready) begin
                bvalid_q <= 1'b0;
            end
        end
    end

    // RAM contents survive reset; a same-edge read sees the pre-commit word
    always_ff @(posedge clk) begin
        if (commit_c) begin
            for (int i = 0; i < 4; i++) begin
                if (w_strb_q[i]) mem[aw_idx_q][8*i +: 8] <= w_data_q[8*i +: 8];
            end
        end
    end

    assign bus.arready = ar_rdy_c;
    assign bus.awready = aw_rdy_c;
    assign bus.wready  = w_rdy_c;
    assign bus.rvalid  = rvalid_c;
    assign bus.rdata   = rdata_q;
    assign bus.rid     = rid_q;
    assign bus.rresp   = 2'b00;
    assign bus.rlast   = 1'b1;
    assign bus.bvalid  = bvalid_q;
    assign bus.bid     = bid_q;
    assign bus.bresp   = 2'b00;

    assign unused_bits = ^{bus.arlen, bus.arsize, bus.arburst, bus.arlock, bus.arcache,
                           bus.arprot, bus.araddr[31:MEM_AW+2], bus.araddr[1:0],
                           bus.awlen, bus.awsize, bus.awburst, bus.awlock, bus.awcache,
                           bus.awprot, bus.awaddr[31:MEM_AW+2], bus.awaddr[1:0],
                           bus.wid, bus.wlast};
endmodule

// File: tb/tb_axi_ram_slave.sv
// Bench for axi_ram_slave: vector table, directed corner sequences, random traffic vs word-array model.
module tb_axi_ram_slave;
    localparam int unsigned MEM_AW = 12;
    localparam int unsigned LAT    = 2;

    logic clk = 1'b0;
    logic resetn;
    int   n_chk  = 0;
    int   n_pass = 0;

    logic [31:0] mem_m [4096];

    axi_ram_slave_if bus ();

    axi_ram_slave #(.MEM_AW(MEM_AW), .READ_LATENCY(LAT)) dut (
        .clk    (clk),
        .resetn (resetn),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          wr;
        logic [31:0] addr;
        logic [3:0]  id;
        logic [31:0] data;   // write data, or expected read data
        logic [3:0]  strb;
        int          ag;
        int          wg;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) $display("FAIL %s: got %h expected %h", name, act, exp);
        else n_pass++;
    endtask

    function automatic void model_wr(input logic [31:0] addr, input logic [31:0] data,
                                     input logic [3:0] strb);
        logic [11:0] idx;
        idx = addr[13:2];
        for (int i = 0; i < 4; i++)
            if (strb[i]) mem_m[idx][8*i +: 8] = data[8*i +: 8];
    endfunction

    task automatic do_write(input logic [31:0] addr, input logic [3:0] id, input logic [31:0] data,
                            input logic [3:0] strb, input int ag, input int wg, input bit rnd);
        int cyc;
        bit aw_done, w_done, aw_hs, w_hs, got;
        cyc = 0; aw_done = 0; w_done = 0; got = 0;
        bus.awid = id; bus.awaddr = addr; bus.wdata = data; bus.wstrb = strb;
        while (!(aw_done && w_done) && cyc < 200) begin
            bus.awvalid = !aw_done && (cyc >= ag);
            bus.wvalid  = !w_done && (cyc >= wg);
            aw_hs = bus.awvalid && bus.awready;
            w_hs  = bus.wvalid && bus.wready;
            @(posedge clk); #1;
            cyc++;
            if (aw_hs) aw_done = 1;
            if (w_hs)  w_done = 1;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        model_wr(addr, data, strb);
        cyc = 0;
        while (!got && cyc < 200) begin
            bus.bready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.bvalid && bus.bready) begin
                got = 1;
                chk("wr_bid", 32'(bus.bid), 32'(id));
                chk("wr_bresp", 32'(bus.bresp), 32'd0);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.bready = 0;
        if (!got) chk("wr_b_timeout", 32'(got), 32'd1);
    endtask

    task automatic do_read(input logic [31:0] addr, input logic [3:0] id, input bit rnd,
                           output logic [31:0] data, output logic [3:0] rid_o);
        int cyc;
        bit got;
        cyc = 0; got = 0; data = '0; rid_o = '0;
        bus.arid = id; bus.araddr = addr; bus.arvalid = 1;
        while (!bus.arready && cyc < 100) begin @(posedge clk); #1; cyc++; end
        @(posedge clk); #1;
        bus.arvalid = 0;
        cyc = 0;
        while (!got && cyc < 200) begin
            bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bus.rvalid && bus.rready) begin
                got = 1;
                data = bus.rdata;
                rid_o = bus.rid;
                chk("rd_rresp", 32'(bus.rresp), 32'd0);
                chk("rd_rlast", 32'(bus.rlast), 32'd1);
            end
            @(posedge clk); #1;
            cyc++;
        end
        bus.rready = 0;
        if (!got) chk("rd_r_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        vec_t        tbl [12];
        logic [31:0] d, a;
        logic [3:0]  r;
        int          n;
        bit          seen;

        bus.arid = 0; bus.araddr = 0; bus.arlen = 0; bus.arsize = 3'd2; bus.arburst = 2'd1;
        bus.arlock = 0; bus.arcache = 0; bus.arprot = 0; bus.arvalid = 0; bus.rready = 0;
        bus.awid = 0; bus.awaddr = 0; bus.awlen = 0; bus.awsize = 3'd2; bus.awburst = 2'd1;
        bus.awlock = 0; bus.awcache = 0; bus.awprot = 0; bus.awvalid = 0;
        bus.wid = 0; bus.wdata = 0; bus.wstrb = 0; bus.wlast = 1; bus.wvalid = 0; bus.bready = 0;
        resetn = 0;

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        chk("rst_arready", 32'(bus.arready), 32'd0);
        chk("rst_awready", 32'(bus.awready), 32'd0);
        chk("rst_wready", 32'(bus.wready), 32'd0);
        chk("rst_rvalid", 32'(bus.rvalid), 32'd0);
        chk("rst_bvalid", 32'(bus.bvalid), 32'd0);
        chk("rst_rdata", bus.rdata, 32'd0);
        chk("rst_ids", 32'({bus.rid, bus.bid}), 32'd0);
        chk("rst_resp", 32'({bus.rresp, bus.bresp}), 32'd0);
        chk("rst_rlast", 32'(bus.rlast), 32'd1);
        resetn = 1;
        @(posedge clk); #1;
        chk("rel_readies", 32'({bus.arready, bus.awready, bus.wready}), 32'h7);

        // Vector table: writes check B, reads check data and id
        tbl[0]  = '{1'b1, 32'h0000_0040, 4'd1,  32'hDEADBEEF, 4'hF, 0, 0};
        tbl[1]  = '{1'b0, 32'h0000_0040, 4'd1,  32'hDEADBEEF, 4'h0, 0, 0};
        tbl[2]  = '{1'b1, 32'h0000_0080, 4'd2,  32'h11223344, 4'hF, 1, 0};
        tbl[3]  = '{1'b1, 32'h0000_0080, 4'd3,  32'hAABBCCDD, 4'h2, 2, 0};
        tbl[4]  = '{1'b0, 32'h0000_0080, 4'd5,  32'h1122CC44, 4'h0, 0, 0};
        tbl[5]  = '{1'b1, 32'h0000_0080, 4'd4,  32'h55667788, 4'h9, 0, 2};
        tbl[6]  = '{1'b0, 32'h0000_0080, 4'd6,  32'h5522CC88, 4'h0, 0, 0};
        tbl[7]  = '{1'b0, 32'h0000_4043, 4'd7,  32'hDEADBEEF, 4'h0, 0, 0};
        tbl[8]  = '{1'b1, 32'hFFFF_C0C4, 4'd8,  32'hCAFEF00D, 4'hF, 0, 0};
        tbl[9]  = '{1'b0, 32'h0000_00C4, 4'd9,  32'hCAFEF00D, 4'h0, 0, 0};
        tbl[10] = '{1'b1, 32'h0000_3FFC, 4'd10, 32'h0BADF00D, 4'hF, 0, 0};
        tbl[11] = '{1'b0, 32'h0000_7FFE, 4'd11, 32'h0BADF00D, 4'h0, 0, 0};
        for (int i = 0; i < 12; i++) begin
            if (tbl[i].wr) begin
                do_write(tbl[i].addr, tbl[i].id, tbl[i].data, tbl[i].strb, tbl[i].ag, tbl[i].wg, 1'b0);
            end else begin
                do_read(tbl[i].addr, tbl[i].id, 1'b0, d, r);
                chk($sformatf("vec%0d_rdata", i), d, tbl[i].data);
                chk($sformatf("vec%0d_rid", i), 32'(r), 32'(tbl[i].id));
            end
        end

        // Read latency from handshake edge into an empty queue
        bus.arid = 4'd5; bus.araddr = 32'h40; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0;
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("lat_edges", 32'(n), 32'(LAT));
        chk("lat_rdata", bus.rdata, 32'hDEADBEEF);
        bus.rready = 1;
        @(posedge clk); #1;
        bus.rready = 0;

        // Two outstanding reads, queue full, in-order return
        do_write(32'h0, 4'd0, 32'hA0A0_0000, 4'hF, 0, 0, 1'b0);
        do_write(32'h4, 4'd0, 32'hB1B1_0004, 4'hF, 0, 0, 1'b0);
        bus.arid = 4'd0; bus.araddr = 32'h0; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arid = 4'd1; bus.araddr = 32'h4;
        @(posedge clk); #1;
        bus.arvalid = 0;
        chk("qfull_arready", 32'(bus.arready), 32'd0);
        repeat (LAT + 2) @(posedge clk);
        #1;
        chk("qfull_head", 32'({bus.rvalid, bus.rid, bus.arready}), 32'({1'b1, 4'd0, 1'b0}));
        chk("qfull_d0", bus.rdata, 32'hA0A0_0000);
        bus.rready = 1;
        @(posedge clk); #1;
        chk("qpop_arready", 32'(bus.arready), 32'd1);
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("q2_lat", 32'(n), 32'(LAT));
        chk("q2_rid", 32'(bus.rid), 32'd1);
        chk("q2_d1", bus.rdata, 32'hB1B1_0004);
        @(posedge clk); #1;
        bus.rready = 0;

        // W ahead of AW, B held off, second write parked behind bvalid
        bus.wdata = 32'h1234_5678; bus.wstrb = 4'hF; bus.wvalid = 1;
        @(posedge clk); #1;
        bus.wvalid = 0;
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (bus.wready) seen = 1;
            @(posedge clk); #1;
        end
        chk("wfirst_wready_low", 32'(seen), 32'd0);
        bus.awid = 4'd2; bus.awaddr = 32'h300; bus.awvalid = 1;
        @(posedge clk); #1;
        bus.awvalid = 0;
        model_wr(32'h300, 32'h1234_5678, 4'hF);
        @(posedge clk); #1;
        chk("wfirst_b", 32'({bus.bvalid, bus.bid}), 32'({1'b1, 4'd2}));
        bus.awid = 4'd3; bus.awaddr = 32'h304; bus.wdata = 32'h9ABC_DEF0;
        bus.awvalid = 1; bus.wvalid = 1;
        @(posedge clk); #1;
        bus.awvalid = 0; bus.wvalid = 0;
        model_wr(32'h304, 32'h9ABC_DEF0, 4'hF);
        seen = 0;
        for (int k = 0; k < 3; k++) begin
            if (!bus.bvalid || bus.bid != 4'd2 || bus.wready || bus.awready) seen = 1;
            @(posedge clk); #1;
        end
        chk("bhold_stable", 32'(seen), 32'd0);
        bus.bready = 1;
        @(posedge clk); #1;
        chk("bhold_second", 32'({bus.bvalid, bus.bid}), 32'({1'b1, 4'd3}));
        @(posedge clk); #1;
        bus.bready = 0;
        chk("bhold_drained", 32'(bus.bvalid), 32'd0);
        do_read(32'h300, 4'd4, 1'b0, d, r);
        chk("bhold_d0", d, 32'h1234_5678);
        do_read(32'h304, 4'd4, 1'b0, d, r);
        chk("bhold_d1", d, 32'h9ABC_DEF0);

        // Commit and rdata load on the same edge: read sees old word
        do_write(32'h500, 4'd1, 32'h0000_0111, 4'hF, 0, 0, 1'b0);
        bus.arid = 4'd6; bus.araddr = 32'h500; bus.arvalid = 1;
        bus.awid = 4'd7; bus.awaddr = 32'h500; bus.wdata = 32'h0000_0222; bus.wstrb = 4'hF;
        for (int k = 0; k < int'(LAT); k++) begin
            bus.awvalid = (k == int'(LAT) - 1);
            bus.wvalid  = (k == int'(LAT) - 1);
            @(posedge clk); #1;
            bus.arvalid = 0;
        end
        bus.awvalid = 0; bus.wvalid = 0;
        model_wr(32'h500, 32'h0000_0222, 4'hF);
        n = 0;
        while (!bus.rvalid && n < 20) begin @(posedge clk); #1; n++; end
        chk("coll_old", bus.rdata, 32'h0000_0111);
        chk("coll_b", 32'({bus.bvalid, bus.bid}), 32'({1'b1, 4'd7}));
        bus.rready = 1; bus.bready = 1;
        @(posedge clk); #1;
        bus.rready = 0; bus.bready = 0;
        do_read(32'h500, 4'd8, 1'b0, d, r);
        chk("coll_new", d, 32'h0000_0222);

        // Reset during an in-flight read
        do_write(32'h100, 4'd2, 32'h0F0F_1234, 4'hF, 0, 0, 1'b0);
        bus.arid = 4'd1; bus.araddr = 32'h100; bus.arvalid = 1;
        @(posedge clk); #1;
        bus.arvalid = 0;
        resetn = 0;
        #1;
        chk("mid_rst_state", 32'({bus.rvalid, bus.arready, bus.awready}), 32'd0);
        @(posedge clk); #1;
        resetn = 1;
        @(posedge clk); #1;
        chk("mid_rst_arready", 32'(bus.arready), 32'd1);
        seen = 0;
        for (int k = 0; k < int'(LAT) + 3; k++) begin
            if (bus.rvalid) seen = 1;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_rvalid", 32'(seen), 32'd0);
        do_read(32'h100, 4'd1, 1'b0, d, r);
        chk("mid_rst_reread", d, 32'h0F0F_1234);
        chk("mid_rst_rid", 32'(r), 32'd1);

        // Random traffic over 8 words, aliased addresses, random strobes and stalls
        for (int k = 0; k < 8; k++) begin
            a = 32'h0;
            a[13:2] = 12'h200 + 12'(k);
            do_write(a, 4'(k), $urandom(), 4'hF, 0, 0, 1'b1);
        end
        for (int k = 0; k < 40; k++) begin
            logic [3:0] id;
            a = $urandom();
            a[13:2] = 12'h200 + 12'($urandom_range(0, 7));
            id = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 1) == 1) begin
                do_write(a, id, $urandom(), 4'($urandom_range(0, 15)),
                         $urandom_range(0, 3), $urandom_range(0, 3), 1'b1);
            end else begin
                do_read(a, id, 1'b1, d, r);
                chk($sformatf("rnd%0d_rdata", k), d, mem_m[a[13:2]]);
                chk($sformatf("rnd%0d_rid", k), 32'(r), 32'(id));
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
